package_feeder: RTL and testbench
=================================

# package_feeder

Transmit side of the package-weight bus that feeds the package sorter. Upstream logic (scale model, test sequencer or host) pushes package weights through a valid/ready handshake into a small FIFO. The block then drives the sorter's 12-bit `weight` bus using the bus protocol:

- each package weight is held nonzero for a fixed number of cycles;
- it is then followed by a mandatory zero gap.

This guarantees exactly one count per package at the sorter. Weights change on the rising edge, so they are stable at the sorter's falling-edge sample point.

## Interface

Parameters:

- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `HOLD`, 2: cycles each weight is driven nonzero; ≥1.
- `GAP`, 1: cycles of zero driven after each weight; ≥1.

Ports:

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `in_weight` input 12: package weight offered by upstream; must be nonzero.
- `in_valid` input 1: `in_weight` is valid this cycle.
- `in_ready` output 1: FIFO can accept this cycle; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `weight` output 12: sorter weight bus, registered.
- `pkt_start` output 1: one-cycle pulse in the first HOLD cycle of each package.
- `busy` output 1: high when state ≠ IDLE or FIFO not empty.
- `sent_count` output 8: packages launched since reset; wraps modulo 256.
- `err_zero` output 1: one-cycle pulse when a zero weight is offered and dropped.

## Operation

- Reset values: `weight`=0, `pkt_start`=0, `sent_count`=0, `err_zero`=0, FIFO empty, state IDLE. `in_ready` is 0 in any cycle where `reset` is 1, and `busy`=0 after reset.
- `in_ready` = !full && !reset. When full, no push occurs even if a pop happens in the same cycle.
- Zero-weight input: if `in_valid && in_ready` and `in_weight`==0, the entry is not enqueued and `err_zero` pulses the next cycle. The bus protocol reserves 0 as the separator.
- Push and pop in the same cycle (FIFO not full) are both performed; occupancy is unchanged.
- FIFO order is strict first-in, first-out. Read and write pointers are log2(DEPTH) bits and wrap; full/empty are derived from an occupancy counter of width log2(DEPTH)+1.
- State machine (one down-counter, width covering max(HOLD,GAP)):
  - IDLE: `weight`=0. If the FIFO is not empty, pop the head, load `weight` with it, load the counter with HOLD-1, assert `pkt_start`, increment `sent_count`, and go to HOLD.
  - HOLD: `weight` is held. If counter==0, set `weight`=0, load the counter with GAP-1, and go to GAP; otherwise decrement.
  - GAP: `weight`=0. If counter≠0, decrement. If counter==0 and the FIFO is not empty, pop and enter HOLD with the same actions as IDLE. If counter==0 and the FIFO is empty, go to IDLE.
- `sent_count` increments 255→0 without a flag.
- Reset mid-operation: at the reset edge `weight` goes to 0 and the FIFO contents and any in-progress package are discarded. The sorter may already have counted that package; this is accepted.

## Timing

- Latency: a weight accepted at edge N into an empty FIFO with state IDLE appears on `weight` after edge N+1. `pkt_start` is high in the same cycle.
- A package occupies exactly HOLD cycles nonzero, then exactly GAP cycles zero. There are never two different nonzero values on consecutive cycles.
- Back-to-back throughput is one package per HOLD+GAP cycles. Defaults give 3 cycles per package.
- `err_zero` is high one cycle after the offending transfer edge.
- `busy` falls in the first IDLE cycle with the FIFO empty.

## Test plan

- **Single package.** Defaults; push 150 at edge 0.
  - `weight`=150 for cycles 1–2, then 0 at cycle 3.
  - `pkt_start` high in cycle 1 only; `sent_count`=1; `busy` low from cycle 4.
- **Back-to-back.** Push 150, 350, 2500 on consecutive edges.
  - `weight` sequence: 150,150,0,350,350,0,2500,2500,0,0.
  - `sent_count`=3.
- **Backpressure.** DEPTH=4, HOLD=4; push every cycle from reset.
  - `in_ready` drops after 5 accepts (1 popped into HOLD, 4 stored).
  - `in_ready` recovers the cycle after the next pop; no weight is lost or reordered.
- **Zero rejection.** Push 0 then 800.
  - `err_zero` pulses once.
  - Only 800 appears on `weight`; `sent_count`=1.
- **Reset mid-HOLD.** Push 1000, 1200; assert `reset` in the second HOLD cycle of 1000.
  - `weight`=0 next cycle; 1200 is never emitted; `sent_count`=0; `busy`=0.
- **Counter wrap.** Push 257 packages of weight 1.
  - `sent_count` reads 255 after package 255, 0 after package 256, and 1 after package 257.

Source files
------------

// File: rtl/package_feeder.sv
// Transmit side of the package-weight bus: a small FIFO feeding a HOLD/GAP framer
// that drives each nonzero weight for HOLD cycles followed by GAP cycles of zero.
module package_feeder #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] in_weight,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] weight,
    output logic        pkt_start,
    output logic        busy,
    output logic [7:0]  sent_count,
    output logic        err_zero
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW    = (MAXHG > 1) ? $clog2(MAXHG) : 1;
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [11:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0]   count_r;
    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [11:0]   weight_r, weight_s;
    logic          pkt_start_r, pkt_start_s;
    logic [7:0]    sent_r, sent_s;
    logic          err_zero_r;
    logic          full_s, empty_s, accept_s, push_s, pop_s, launch_s;

    assign full_s   = (count_r == FULL_CNT);
    assign empty_s  = (count_r == {(AW + 1){1'b0}});
    assign in_ready = !full_s && !reset;
    assign accept_s = in_valid && in_ready;
    // Zero is the bus separator, so it is never enqueued.
    assign push_s   = accept_s && (in_weight != 12'd0);

    assign weight     = weight_r;
    assign pkt_start  = pkt_start_r;
    assign sent_count = sent_r;
    assign err_zero   = err_zero_r;
    assign busy       = (state_r != ST_IDLE) || !empty_s;

    // FIFO storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_weight;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Framer next-state and bus outputs.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        weight_s    = weight_r;
        pkt_start_s = 1'b0;
        sent_s      = sent_r;
        pop_s       = 1'b0;
        launch_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                weight_s = 12'd0;
                if (!empty_s) begin
                    launch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r == {CW{1'b0}}) begin
                    weight_s = 12'd0;
                    cnt_s    = GAP_LD;
                    state_s  = ST_GAP;
                end else begin
                    cnt_s = cnt_r - CW'(1);
                end
            end
            ST_GAP: begin
                weight_s = 12'd0;
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_s = cnt_r - CW'(1);
                end else if (!empty_s) begin
                    launch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: begin
                weight_s = 12'd0;
                state_s  = ST_IDLE;
            end
        endcase
        // A launch from IDLE or from the last GAP cycle is identical.
        if (launch_s) begin
            pop_s       = 1'b1;
            weight_s    = mem_r[rd_ptr_r];
            cnt_s       = HOLD_LD;
            pkt_start_s = 1'b1;
            sent_s      = sent_r + 8'd1;
            state_s     = ST_HOLD;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Framer registers and registered error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            weight_r    <= 12'd0;
            pkt_start_r <= 1'b0;
            sent_r      <= 8'd0;
            err_zero_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            weight_r    <= weight_s;
            pkt_start_r <= pkt_start_s;
            sent_r      <= sent_s;
            err_zero_r  <= accept_s && (in_weight == 12'd0);
        end
    end

endmodule

// File: tb/tb_package_feeder.sv
// Bench for package_feeder: directed and random steps against a schedule-based
// model that computes each package's start cycle from acceptance time.
module tb_package_feeder;

    localparam int DEPTH = 4;
    localparam int HOLD  = 2;
    localparam int GAP   = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] in_weight;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] weight;
    logic        pkt_start;
    logic        busy;
    logic [7:0]  sent_count;
    logic        err_zero;

    package_feeder #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .in_weight(in_weight), .in_valid(in_valid),
        .in_ready(in_ready), .weight(weight), .pkt_start(pkt_start), .busy(busy),
        .sent_count(sent_count), .err_zero(err_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: cycle k is the period after rising edge k.
    int cyc = 0;
    int pend_w[$];
    int pend_s[$];
    int cur_w = 0;
    int cur_s = 0;
    bit cur_v = 1'b0;
    int sent = 0;
    bit err_exp = 1'b0;
    int last_s = -1000;
    int accepted = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend_w.delete();
        pend_s.delete();
        cur_v   = 1'b0;
        sent    = 0;
        err_exp = 1'b0;
        last_s  = -1000;
    endtask

    // One clock: drive inputs, check this cycle's outputs, then advance the model.
    task automatic step(input logic r, input logic v, input logic [11:0] w);
        bit rdy;
        int s;
        @(negedge clk);
        reset = r;
        in_valid = v;
        in_weight = w;
        #1;
        rdy = !r && (pend_w.size() < DEPTH);
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        chk("weight", {20'd0, weight}, (cur_v && cyc < cur_s + HOLD) ? cur_w : 0);
        chk("pkt_start", {31'd0, pkt_start}, (cur_v && cyc == cur_s) ? 1 : 0);
        chk("busy", {31'd0, busy},
            (pend_w.size() > 0 || (cur_v && cyc < cur_s + HOLD + GAP)) ? 1 : 0);
        chk("sent_count", {24'd0, sent_count}, sent % 256);
        chk("err_zero", {31'd0, err_zero}, {31'd0, err_exp});
        @(posedge clk);
        if (r) begin
            model_clear();
        end else begin
            err_exp = v && rdy && (w == 12'd0);
            if (v && rdy && w != 12'd0) begin
                s = (cyc + 2 > last_s + HOLD + GAP) ? cyc + 2 : last_s + HOLD + GAP;
                pend_w.push_back(int'(w));
                pend_s.push_back(s);
                last_s = s;
                accepted++;
            end
        end
        cyc++;
        if (pend_s.size() > 0 && pend_s[0] == cyc) begin
            cur_w = pend_w.pop_front();
            cur_s = pend_s.pop_front();
            cur_v = 1'b1;
            sent++;
        end
    endtask

    initial begin
        int base;
        reset = 1'b1;
        in_valid = 1'b0;
        in_weight = 12'd0;
        repeat (2) @(posedge clk);
        model_clear();

        // Reset state with reset still high.
        step(1'b1, 1'b0, 12'd0);
        chk("reset_weight", {20'd0, weight}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        // Single package.
        step(1'b0, 1'b1, 12'd150);
        repeat (5) step(1'b0, 1'b0, 12'd0);
        chk("single_sent", {24'd0, sent_count}, 32'd1);

        // Back-to-back.
        step(1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b1, 12'd150);
        step(1'b0, 1'b1, 12'd350);
        step(1'b0, 1'b1, 12'd2500);
        repeat (10) step(1'b0, 1'b0, 12'd0);
        chk("b2b_sent", {24'd0, sent_count}, 32'd3);

        // Backpressure: push every cycle.
        step(1'b1, 1'b0, 12'd0);
        repeat (30) step(1'b0, 1'b1, 12'($urandom_range(4095, 1)));
        repeat (20) step(1'b0, 1'b0, 12'd0);

        // Zero rejection.
        step(1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b1, 12'd0);
        step(1'b0, 1'b1, 12'd800);
        repeat (6) step(1'b0, 1'b0, 12'd0);
        chk("zero_sent", {24'd0, sent_count}, 32'd1);

        // Reset in the second HOLD cycle of 1000.
        step(1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b1, 12'd1000);
        step(1'b0, 1'b1, 12'd1200);
        step(1'b0, 1'b0, 12'd0);
        step(1'b1, 1'b0, 12'd0);
        repeat (6) step(1'b0, 1'b0, 12'd0);
        chk("midhold_sent", {24'd0, sent_count}, 32'd0);
        chk("midhold_busy", {31'd0, busy}, 32'd0);

        // Counter wrap: 257 packages of weight 1.
        step(1'b1, 1'b0, 12'd0);
        base = accepted;
        for (int i = 0; i < 2000 && accepted - base < 257; i++) begin
            step(1'b0, 1'b1, 12'd1);
        end
        chk("wrap_accepted", accepted - base, 32'd257);
        repeat (20) step(1'b0, 1'b0, 12'd0);
        chk("wrap_sent", {24'd0, sent_count}, 32'd1);

        // Random traffic with occasional zeros and resets.
        for (int i = 0; i < 400; i++) begin
            logic [11:0] w;
            w = ($urandom_range(7, 0) == 0) ? 12'd0 : 12'($urandom_range(4095, 1));
            step(($urandom_range(63, 0) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(1, 0) == 1) ? 1'b1 : 1'b0, w);
        end
        repeat (20) step(1'b0, 1'b0, 12'd0);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
